bist_scheduler: RTL

Sequences up to NUM_MEMS memory BIST controllers, one at a time, in ascending index order. Each child controller runs its own memory test. The scheduler starts each selected child, waits for its completion or a timeout, and aggregates the results into one chip-level status: a pass flag, a fail mask, a timeout mask and a saturating total error count. It sits between the test-access/JTAG control register and the per-memory BIST controllers.

---
 rtl/bist_scheduler_if.sv | 33 +++
 rtl/bist_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bist_scheduler_if.sv
// ============================================================================
// Module      : bist_scheduler_if
// Description : Scheduler-to-child BIST controller bus (start pulses, done,
//               pass and packed error counts).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bist_scheduler_if #(
    parameter int NUM_MEMS  = 4,
    parameter int ERR_WIDTH = 32
);
    logic [NUM_MEMS-1:0]           bist_start_o;
    logic [NUM_MEMS-1:0]           bist_done_i;
    logic [NUM_MEMS-1:0]           bist_pass_i;
    logic [NUM_MEMS*ERR_WIDTH-1:0] bist_err_cnt_i;

    modport master (
        output bist_start_o,
        input  bist_done_i,
        input  bist_pass_i,
        input  bist_err_cnt_i
    );

    modport slave (
        input  bist_start_o,
        output bist_done_i,
        output bist_pass_i,
        output bist_err_cnt_i
    );
endinterface

`default_nettype wire

// File: rtl/bist_scheduler.sv
// ============================================================================
// Module      : bist_scheduler
// Description : Runs selected memory BIST controllers one at a time in
//               ascending index order and aggregates pass/fail/timeout/errors.
//               Optional macro BIST_SCHED_STOP_ON_FAIL_EN ends the run at the
//               first failing or timed-out child.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_scheduler #(
    parameter int NUM_MEMS       = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int ERR_WIDTH      = 32,
    localparam int c_cur_w       = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  sched_start,
    input  wire logic                  sched_abort,
    input  wire logic [NUM_MEMS-1:0]   mem_select,
    bist_scheduler_if.master           bist,
    output logic                       sched_busy,
    output logic                       sched_done,
    output logic                       sched_pass,
    output logic                       sched_aborted,
    output logic [NUM_MEMS-1:0]        fail_mask,
    output logic [NUM_MEMS-1:0]        timeout_mask,
    output logic [c_cur_w-1:0]         cur_mem,
    output logic [ERR_WIDTH-1:0]       total_errors
);

    localparam int                  c_tmr_w    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_tmr_w-1:0]  c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_MEMS-1:0] c_one      = NUM_MEMS'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RECORD = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 r_state;
    logic [NUM_MEMS-1:0]    r_pending;
    logic [NUM_MEMS-1:0]    r_done_prev;
    logic [c_tmr_w-1:0]     r_timer;
    logic                   r_cap_pass;
    logic                   r_cap_to;
    logic [ERR_WIDTH-1:0]   r_cap_err;

    logic [c_cur_w-1:0]     w_next_idx;
    logic                   w_done_edge;
    logic [ERR_WIDTH-1:0]   w_err_sel;
    logic [ERR_WIDTH:0]     w_sum;
    logic                   w_fail;

    // Scanning downward leaves the lowest pending index as the winner.
    always_comb begin
        w_next_idx = '0;
        for (int i = NUM_MEMS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_next_idx = c_cur_w'(i);
            end
        end
    end

    assign w_done_edge = bist.bist_done_i[cur_mem] & ~r_done_prev[cur_mem];
    assign w_err_sel   = bist.bist_err_cnt_i[cur_mem*ERR_WIDTH +: ERR_WIDTH];
    assign w_sum       = {1'b0, total_errors} + {1'b0, r_cap_err};
    assign w_fail      = ~r_cap_pass | r_cap_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_IDLE;
            r_pending         <= '0;
            r_done_prev       <= '0;
            r_timer           <= '0;
            r_cap_pass        <= 1'b0;
            r_cap_to          <= 1'b0;
            r_cap_err         <= '0;
            bist.bist_start_o <= '0;
            sched_busy        <= 1'b0;
            sched_done        <= 1'b0;
            sched_pass        <= 1'b0;
            sched_aborted     <= 1'b0;
            fail_mask         <= '0;
            timeout_mask      <= '0;
            cur_mem           <= '0;
            total_errors      <= '0;
        end else begin
            // History runs for every bit so stale levels never look like edges.
            r_done_prev       <= bist.bist_done_i;
            bist.bist_start_o <= '0;

            if (sched_abort && (r_state == S_SELECT || r_state == S_LAUNCH ||
                                r_state == S_WAIT   || r_state == S_RECORD)) begin
                r_state       <= S_DONE;
                sched_busy    <= 1'b0;
                sched_done    <= 1'b1;
                sched_pass    <= 1'b0;
                sched_aborted <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (sched_start) begin
                            r_pending     <= mem_select;
                            fail_mask     <= '0;
                            timeout_mask  <= '0;
                            total_errors  <= '0;
                            sched_pass    <= 1'b0;
                            sched_aborted <= 1'b0;
                            sched_done    <= 1'b0;
                            sched_busy    <= 1'b1;
                            r_state       <= S_SELECT;
                        end
                    end
                    S_SELECT: begin
                        if (r_pending == '0) begin
                            r_state    <= S_DONE;
                            sched_busy <= 1'b0;
                            sched_done <= 1'b1;
                            sched_pass <= (fail_mask == '0);
                        end else begin
                            cur_mem           <= w_next_idx;
                            bist.bist_start_o <= c_one << w_next_idx;
                            r_state           <= S_LAUNCH;
                        end
                    end
                    S_LAUNCH: begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        r_timer <= r_timer + 1'b1;
                        // A done edge coinciding with the last timer cycle wins.
                        if (w_done_edge) begin
                            r_cap_pass <= bist.bist_pass_i[cur_mem];
                            r_cap_err  <= w_err_sel;
                            r_cap_to   <= 1'b0;
                            r_state    <= S_RECORD;
                        end else if (r_timer == c_tmr_last) begin
                            r_cap_pass <= 1'b0;
                            r_cap_err  <= '0;
                            r_cap_to   <= 1'b1;
                            r_state    <= S_RECORD;
                        end
                    end
                    S_RECORD: begin
                        fail_mask[cur_mem]    <= fail_mask[cur_mem] | w_fail;
                        timeout_mask[cur_mem] <= timeout_mask[cur_mem] | r_cap_to;
                        total_errors          <= w_sum[ERR_WIDTH] ? '1 : w_sum[ERR_WIDTH-1:0];
                        r_pending[cur_mem]    <= 1'b0;
`ifdef BIST_SCHED_STOP_ON_FAIL_EN
                        if (w_fail) begin
                            r_state    <= S_DONE;
                            sched_busy <= 1'b0;
                            sched_done <= 1'b1;
                            sched_pass <= 1'b0;
                        end else begin
                            r_state <= S_SELECT;
                        end
`else
                        r_state <= S_SELECT;
`endif
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
